// File: rtl/mc_controller.sv
// Multi-cycle RV32 main controller: FETCH/DECODE/EXEC/MEM/IO/WB sequencing
// with fixed-latency memory strobes and an ack/timeout IO handshake.
module mc_controller #(
  parameter int ADDR_W     = 32,
  parameter int IO_BITS    = 22,
  parameter int MEM_LAT    = 1,
  parameter int IO_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        opcode,
  input  logic [1:0]        ecall,
  input  logic [ADDR_W-1:0] alu_result,
  input  logic              io_ack,
  output logic              ir_write,
  output logic              pc_write,
  output logic              reg_write,
  output logic              alu_src,
  output logic [1:0]        alu_op,
  output logic              branch,
  output logic              jump,
  output logic              memorio_to_reg,
  output logic              mem_read,
  output logic              mem_write,
  output logic              io_read,
  output logic              io_write,
  output logic              io_timeout,
  output logic              illegal,
  output logic [2:0]        state
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_AUI  = 7'b0010111;
  localparam logic [6:0] OP_SYS  = 7'b1110011;

  localparam int CMAX = (MEM_LAT > IO_TIMEOUT) ? MEM_LAT : IO_TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_IO     = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  state_t        r_state;
  logic          r_armed;
  logic [6:0]    r_op;
  logic [1:0]    r_ecall;
  logic          r_io;
  logic          r_rd;
  logic [CW-1:0] r_cnt;

  logic w_known;
  logic w_r, w_i, w_ld, w_st, w_br;
  logic w_jal, w_jalr, w_lui, w_aui, w_sys;
  logic w_ec_io;
  logic w_io_hit;
  logic w_mem_last;
  logic w_io_last;
  logic w_unused;

  assign w_known = opcode inside {OP_R, OP_I, OP_LD, OP_ST,
                                  OP_BR, OP_JAL, OP_JALR,
                                  OP_LUI, OP_AUI, OP_SYS};

  assign w_r    = (r_op == OP_R);
  assign w_i    = (r_op == OP_I);
  assign w_ld   = (r_op == OP_LD);
  assign w_st   = (r_op == OP_ST);
  assign w_br   = (r_op == OP_BR);
  assign w_jal  = (r_op == OP_JAL);
  assign w_jalr = (r_op == OP_JALR);
  assign w_lui  = (r_op == OP_LUI);
  assign w_aui  = (r_op == OP_AUI);
  assign w_sys  = (r_op == OP_SYS);

  assign w_ec_io    = r_ecall[0] ^ r_ecall[1];
  assign w_io_hit   = &alu_result[ADDR_W-1 -: IO_BITS];
  assign w_mem_last = (r_cnt == CW'(MEM_LAT - 1));
  assign w_io_last  = (r_cnt == CW'(IO_TIMEOUT - 1));
  assign w_unused   = ^{alu_result, r_io};

  // First FETCH after reset is an idle bubble so reset leaves every strobe low
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_armed <= 1'b0;
      r_op    <= '0;
      r_ecall <= '0;
      r_io    <= 1'b0;
      r_rd    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_FETCH: begin
          r_armed <= 1'b1;
          if (r_armed) r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_op    <= opcode;
          r_ecall <= ecall;
          r_state <= w_known ? S_EXEC : S_TRAP;
        end
        S_EXEC: begin
          r_cnt <= '0;
          unique case (1'b1)
            w_br: begin
              r_rd    <= 1'b0;
              r_state <= S_FETCH;
            end
            w_ld, w_st: begin
              r_io    <= w_io_hit;
              r_rd    <= w_ld;
              r_state <= w_io_hit ? S_IO : S_MEM;
            end
            w_sys: begin
              r_io    <= w_ec_io;
              r_rd    <= (r_ecall == 2'b01);
              r_state <= w_ec_io ? S_IO : S_FETCH;
            end
            default: begin
              r_rd    <= 1'b0;
              r_state <= S_WB;
            end
          endcase
        end
        S_MEM: begin
          if (w_mem_last) r_state <= r_rd ? S_WB : S_FETCH;
          else r_cnt <= r_cnt + 1'b1;
        end
        S_IO: begin
          if (io_ack || w_io_last) r_state <= r_rd ? S_WB : S_FETCH;
          else r_cnt <= r_cnt + 1'b1;
        end
        S_WB:    r_state <= S_FETCH;
        S_TRAP:  r_state <= S_TRAP;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    ir_write       = 1'b0;
    pc_write       = 1'b0;
    reg_write      = 1'b0;
    alu_src        = 1'b0;
    alu_op         = 2'b00;
    branch         = 1'b0;
    jump           = 1'b0;
    memorio_to_reg = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    io_read        = 1'b0;
    io_write       = 1'b0;
    io_timeout     = 1'b0;
    illegal        = 1'b0;
    unique case (r_state)
      S_FETCH: ir_write = r_armed;
      S_EXEC: begin
        unique case (1'b1)
          w_r: alu_op = 2'b10;
          w_i, w_ld, w_st, w_lui, w_aui: alu_src = 1'b1;
          w_jalr: begin
            alu_src = 1'b1;
            jump    = 1'b1;
          end
          w_jal: jump = 1'b1;
          w_br: begin
            branch   = 1'b1;
            alu_op   = 2'b01;
            pc_write = 1'b1;
          end
          w_sys: pc_write = !w_ec_io;
          default: ;
        endcase
      end
      S_MEM: begin
        mem_read  = r_rd;
        mem_write = !r_rd;
        pc_write  = !r_rd && w_mem_last;
      end
      // Ack and timeout both close the access in the current cycle
      S_IO: begin
        io_read    = r_rd;
        io_write   = !r_rd;
        io_timeout = !io_ack && w_io_last;
        pc_write   = !r_rd && (io_ack || w_io_last);
      end
      S_WB: begin
        reg_write      = 1'b1;
        pc_write       = 1'b1;
        memorio_to_reg = r_rd;
      end
      S_TRAP:  illegal = 1'b1;
      default: ;
    endcase
  end

  assign state = r_state;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: per-instruction vector table plus
// hand-written trap and mid-access reset sequences.
module tb_mc_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  opcode;
  logic [1:0]  ecall;
  logic [31:0] alu_result;
  logic        io_ack;
  logic        ir_write, pc_write, reg_write, alu_src;
  logic [1:0]  alu_op;
  logic        branch, jump, memorio_to_reg;
  logic        mem_read, mem_write, io_read, io_write;
  logic        io_timeout, illegal;
  logic [2:0]  state;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mc_controller #(
    .ADDR_W    (32),
    .IO_BITS   (22),
    .MEM_LAT   (3),
    .IO_TIMEOUT(8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .ecall         (ecall),
    .alu_result    (alu_result),
    .io_ack        (io_ack),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .reg_write     (reg_write),
    .alu_src       (alu_src),
    .alu_op        (alu_op),
    .branch        (branch),
    .jump          (jump),
    .memorio_to_reg(memorio_to_reg),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .io_read       (io_read),
    .io_write      (io_write),
    .io_timeout    (io_timeout),
    .illegal       (illegal),
    .state         (state)
  );

  logic [13:0] w_strobes;
  logic [17:0] w_all;
  assign w_strobes = {ir_write, pc_write, reg_write, alu_src, alu_op,
                      branch, jump, memorio_to_reg, mem_read, mem_write,
                      io_read, io_write, io_timeout};
  assign w_all = {w_strobes, illegal, state};

  // ack: -1 never, -2 held high always, N>=0 high on IO cycle N+1
  typedef struct {
    logic [6:0]  op;
    logic [1:0]  ec;
    logic [31:0] addr;
    int          ack;
    int          cyc;
    logic [31:0] sig;
    int pcw, pcst, rw, mr, mw, ir, iw, to, to_at, m2r, br, jp;
    int aop, asrc;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string nm, input int idx,
                     input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL v%0d %s: got 0x%0h expected 0x%0h",
                  idx, nm, act, exp);
  endtask

  task automatic wait_ir(input int idx);
    int n = 0;
    while (!ir_write && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_ir_write", idx, ir_write, 1);
  endtask

  // Entered on a FETCH cycle with ir_write high; leaves on the next one
  task automatic run(input vec_t v, input int idx);
    int n = 0, io_n = 0;
    int pcw = 0, pcst = 0, rw = 0, mr = 0, mw = 0, ir = 0, iw = 0;
    int to = 0, to_at = 0, m2r = 0, br = 0, jp = 0, viol = 0;
    int aop = -1, asrc = -1;
    logic [31:0] sig = '0;
    opcode     = v.op;
    ecall      = v.ec;
    alu_result = v.addr;
    do begin
      io_ack = (v.ack == -2) ||
               (state == 3'd4 && v.ack >= 0 && io_n == v.ack);
      #1;
      n++;
      sig = (sig << 4) | 32'(state);
      if (pc_write) begin
        pcw++;
        pcst = int'(state);
      end
      if (state == 3'd4) io_n++;
      if (io_timeout) begin
        to++;
        to_at = io_n;
      end
      if (state == 3'd2) begin
        aop  = int'(alu_op);
        asrc = int'(alu_src);
      end
      rw  += int'(reg_write);
      mr  += int'(mem_read);
      mw  += int'(mem_write);
      ir  += int'(io_read);
      iw  += int'(io_write);
      m2r += int'(memorio_to_reg);
      br  += int'(branch);
      jp  += int'(jump);
      if (((mem_read | mem_write) && (io_read | io_write)) ||
          $countones({mem_read, mem_write, io_read, io_write}) > 1)
        viol++;
      @(posedge clk); #1;
    end while (!ir_write && n < 64);
    io_ack = 1'b0;
    chk("cycles", idx, n, v.cyc);
    chk("state_trace", idx, sig, v.sig);
    chk("pc_write_count", idx, pcw, v.pcw);
    chk("pc_write_state", idx, pcst, v.pcst);
    chk("reg_write", idx, rw, v.rw);
    chk("mem_read", idx, mr, v.mr);
    chk("mem_write", idx, mw, v.mw);
    chk("io_read", idx, ir, v.ir);
    chk("io_write", idx, iw, v.iw);
    chk("io_timeout", idx, to, v.to);
    chk("io_timeout_at", idx, to_at, v.to_at);
    chk("memorio_to_reg", idx, m2r, v.m2r);
    chk("branch", idx, br, v.br);
    chk("jump", idx, jp, v.jp);
    chk("alu_op", idx, aop, v.aop);
    chk("alu_src", idx, asrc, v.asrc);
    chk("req_overlap", idx, viol, 0);
  endtask

  initial begin
    int n;
    int bad;
    //         op          ec     addr          ack cyc sig
    //         pcw pcst rw mr mw ir iw to to_at m2r br jp aop asrc
    vecs[0]  = '{7'b0110011, 2'b00, 32'h0000_0000, -1, 4, 32'h0125,
                 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0};
    vecs[1]  = '{7'b0010011, 2'b00, 32'h0000_0000, -1, 4, 32'h0125,
                 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    vecs[2]  = '{7'b0000011, 2'b00, 32'h0000_0010, -1, 7, 32'h0123335,
                 1, 5, 1, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1};
    vecs[3]  = '{7'b0100011, 2'b00, 32'h0000_0020, -1, 6, 32'h012333,
                 1, 3, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    vecs[4]  = '{7'b1100011, 2'b00, 32'h0000_0000, -1, 3, 32'h012,
                 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0};
    vecs[5]  = '{7'b1101111, 2'b00, 32'h0000_0000, -1, 4, 32'h0125,
                 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    vecs[6]  = '{7'b1100111, 2'b00, 32'h0000_0000, -1, 4, 32'h0125,
                 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1};
    vecs[7]  = '{7'b0110111, 2'b00, 32'h0000_0000, -1, 4, 32'h0125,
                 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    vecs[8]  = '{7'b0100011, 2'b00, 32'hFFFF_FC60, 5, 9, 32'h12444444,
                 1, 4, 0, 0, 0, 0, 6, 0, 0, 0, 0, 0, 0, 1};
    vecs[9]  = '{7'b0000011, 2'b00, 32'hFFFF_FC00, 0, 5, 32'h01245,
                 1, 5, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1};
    vecs[10] = '{7'b1110011, 2'b01, 32'h0000_0000, -1, 12, 32'h44444445,
                 1, 5, 1, 0, 0, 8, 0, 1, 8, 1, 0, 0, 0, 0};
    vecs[11] = '{7'b1110011, 2'b10, 32'h0000_0000, 2, 6, 32'h012444,
                 1, 4, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0};
    vecs[12] = '{7'b1110011, 2'b00, 32'h0000_0000, -1, 3, 32'h012,
                 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[13] = '{7'b0000011, 2'b00, 32'hFFFF_F800, -1, 7, 32'h0123335,
                 1, 5, 1, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1};
    vecs[14] = '{7'b0110011, 2'b00, 32'h0000_0000, -2, 4, 32'h0125,
                 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0};
    vecs[15] = '{7'b0100011, 2'b00, 32'h0000_0020, -2, 6, 32'h012333,
                 1, 3, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    vecs[16] = '{7'b0010111, 2'b00, 32'h0000_0000, -1, 4, 32'h0125,
                 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

    rst_n      = 1'b0;
    opcode     = '0;
    ecall      = '0;
    alu_result = '0;
    io_ack     = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset_outputs", 100, w_all, 0);
    rst_n = 1'b1;
    wait_ir(100);

    foreach (vecs[i]) run(vecs[i], i);

    // Unknown opcode traps and stays silent until reset
    opcode = 7'b0000000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("trap_state", 200, state, 6);
    chk("trap_illegal", 200, illegal, 1);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      io_ack = k[0];
      @(posedge clk); #1;
      if (w_strobes != '0 || state != 3'd6 || !illegal) bad++;
    end
    io_ack = 1'b0;
    chk("trap_quiet", 200, bad, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("trap_reset_state", 200, state, 0);
    chk("trap_reset_illegal", 200, illegal, 0);
    chk("trap_reset_all", 200, w_all, 0);
    wait_ir(200);

    // Reset landing on the 2nd MEM cycle of a load
    opcode     = 7'b0000011;
    alu_result = 32'h0000_0010;
    n = 0;
    while (state != 3'd3 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("midmem_reach", 300, state, 3);
    @(posedge clk); #1;
    chk("midmem_read", 300, mem_read, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midmem_reset_all", 300, w_all, 0);
    wait_ir(300);
    run(vecs[0], 301);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multi-cycle successor to the single-cycle RV32 main controller. It sequences each instruction through FETCH/DECODE/EXEC/MEM/IO/WB states.
- Memory accesses take a parametrised fixed latency. IO accesses use a ready/ack handshake with a timeout. IO-versus-memory routing uses a parametrised address prefix.
- Sits between the instruction register/ALU datapath and the memory/IO bus of the multi-cycle CPU.

Parameters:
ADDR_W, 32, ALU result / address width
IO_BITS, 22, number of upper address bits compared for IO decode (1..ADDR_W)
MEM_LAT, 1, cycles mem_read/mem_write stay asserted per access (>=1)
IO_TIMEOUT, 255, max cycles waiting for io_ack before abandoning access (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
opcode  in  7  instruction opcode from IR, valid from DECODE onward
ecall  in  2  ecall service code, valid from DECODE onward
alu_result  in  ADDR_W  registered ALU output, stable throughout MEM/IO
io_ack  in  1  IO device completion strobe
ir_write  out  1  load instruction register
pc_write  out  1  update PC; exactly one pulse per instruction
reg_write  out  1  register file write enable
alu_src  out  1  0=rs2, 1=immediate
alu_op  out  2  00 add, 01 branch compare, 10 funct-decoded
branch  out  1  branch instruction in EXEC
jump  out  1  jal/jalr in EXEC
memorio_to_reg  out  1  writeback source is mem/IO data
mem_read  out  1  data memory read
mem_write  out  1  data memory write
io_read  out  1  IO read request
io_write  out  1  IO write request
io_timeout  out  1  one-cycle pulse on abandoned IO access
illegal  out  1  sticky: unknown opcode reached, core halted
state  out  3  current state encoding (debug)

Behaviour:
- Reset (rst_n low at clk edge): state=FETCH(0); all outputs 0; counters cleared; illegal cleared. Reset wins over every other event, including mid-MEM/IO; no residual request after reset.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, IO=4, WB=5, TRAP=6.
- FETCH: ir_write=1 for one cycle, then DECODE.
- DECODE: opcode/ecall latched internally; unknown opcode -> TRAP; else -> EXEC.
- EXEC: alu_src/alu_op per class.
  - R: 0/10.
  - I-ALU, load, store, jalr, lui, auipc: 1/00.
  - Branch: branch=1, alu_op=01, pc_write=1 -> FETCH.
  - jal/jalr: jump=1 -> WB.
  - ALU, lui, auipc -> WB.
  - Load/store: IO decode on alu_result[ADDR_W-1 -: IO_BITS] all ones -> IO, else -> MEM. Decision is latched.
  - ecall 01 -> IO (read). ecall 10 -> IO (write). Other ecall: pc_write=1 -> FETCH.
- MEM: mem_read (load) or mem_write (store) held exactly MEM_LAT cycles.
  - After the last cycle, load -> WB.
  - Store asserts pc_write on its last MEM cycle -> FETCH.
- IO: io_read/io_write held until io_ack sampled high, inclusive of the ack cycle.
  - Request drops the cycle after ack. Read -> WB; write: pc_write on ack cycle -> FETCH.
  - io_ack high in the first IO cycle completes in 1 cycle.
  - No ack after IO_TIMEOUT cycles: request drops, io_timeout pulses on that last cycle, then same exit as ack. A read still writes back whatever data is on the bus.
  - io_ack outside IO is ignored.
- WB: reg_write=1, pc_write=1 for one cycle. memorio_to_reg=1 iff the instruction was load or IO read. Then -> FETCH.
- TRAP: illegal=1, all strobes 0, stays until reset.
- Invariants:
  - mem_* and io_* are never simultaneously high.
  - At most one request line high.
  - Outputs are Moore (function of state/latched info/counter only), except io_timeout/pc_write on the ack cycle.
- CPI: ALU/jal = 4; branch = 3; load = 4+MEM_LAT; store = 3+MEM_LAT; IO = 3/4 + wait.

Test Plan:
- add (opcode 0110011), reset released -> states 0,1,2,5,0; reg_write high only in WB; alu_op=10; exactly one pc_write; 4 cycles.
- lw, alu_result=0x0000_0010, MEM_LAT=3 -> mem_read high exactly 3 cycles, then WB with memorio_to_reg=1; io_read never high.
- sw, alu_result=0xFFFF_FC60, io_ack after 5 cycles -> io_write high 6 cycles, pc_write on ack cycle, reg_write never high.
- ecall 01 with io_ack held low, IO_TIMEOUT=8 -> io_read high 8 cycles, io_timeout single pulse on 8th, then WB.
- opcode 0000000 -> TRAP (state 6), illegal=1, no further strobes for 20 cycles; rst_n low one edge -> state 0, illegal=0.
- rst_n low during 2nd MEM cycle of lw -> next cycle all outputs 0, state FETCH.
